triangle_channel_gen: RTL and testbench

Parametrised next-generation triangle wave channel for the APU.
- Timer, linear counter and length counter are gated by external frame-sequencer quarter/half-frame strobes; channel-enable and halt semantics are corrected.
- Register-write interface replaces the three free-running input registers.
- Sits between the CPU register decoder / frame sequencer and the channel mixer.

---
 rtl/apu_pkg.sv | 19 +
 rtl/apu_length_counter.sv | 41 ++++
 rtl/triangle_channel_gen.sv | 118 +++++++++++
 tb/tb_triangle_channel_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter load table and triangle register map.
package apu_pkg;

    localparam logic [1:0] TRI_REG_CTRL = 2'd0;
    localparam logic [1:0] TRI_REG_TLO  = 2'd2;
    localparam logic [1:0] TRI_REG_THI  = 2'd3;

    localparam logic [7:0] LENGTH_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    function automatic logic [7:0] length_lookup(input logic [4:0] idx);
        return LENGTH_TABLE[idx];
    endfunction

endpackage

// File: rtl/apu_length_counter.sv
// Length counter shared by the APU channels: load, halt, half-frame decay, enable clear.
module apu_length_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             halt,
    input  logic             half_frame,
    input  logic             enable,
    output logic [LEN_W-1:0] count,
    output logic             active
);

    logic [LEN_W-1:0] count_q, count_d;

    // A disabled channel pins the count at zero and swallows loads; a load beats a decay.
    always_comb begin
        count_d = count_q;
        if (!enable) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (half_frame && !halt && (count_q != '0)) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign active = (count_q != '0);

endmodule

// File: rtl/triangle_channel_gen.sv
// Triangle wave channel: period timer, linear counter, length counter and 32-step sequencer.
module triangle_channel_gen
    import apu_pkg::*;
#(
    parameter int TIMER_W    = 11,
    parameter int OUT_W      = 4,
    parameter int LIN_W      = 7,
    parameter int LEN_W      = 8,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             quarter_frame,
    input  logic             half_frame,
    input  logic             enable,
    output logic [OUT_W-1:0] wave,
    output logic             length_active
);

    logic               ctrl_q, ctrl_d;
    logic [LIN_W-1:0]   lin_reload_q, lin_reload_d;
    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [LIN_W-1:0]   linear_q, linear_d;
    logic               reload_flag_q, reload_flag_d;
    logic [OUT_W:0]     step_q, step_d;

    logic               wr_ctrl, wr_tlo, wr_thi;
    logic               step_tick, period_ok;
    logic [LEN_W-1:0]   length_count;

    assign wr_ctrl   = wr_en && (wr_addr == TRI_REG_CTRL);
    assign wr_tlo    = wr_en && (wr_addr == TRI_REG_TLO);
    assign wr_thi    = wr_en && (wr_addr == TRI_REG_THI);
    assign step_tick = (timer_q == '0);
    assign period_ok = (MIN_PERIOD == 0) || (period_q >= TIMER_W'(MIN_PERIOD));

    always_comb begin
        ctrl_d        = ctrl_q;
        lin_reload_d  = lin_reload_q;
        period_d      = period_q;
        timer_d       = step_tick ? period_q : timer_q - TIMER_W'(1);
        linear_d      = linear_q;
        reload_flag_d = reload_flag_q;
        step_d        = step_q;

        if (wr_ctrl) begin
            ctrl_d       = wr_data[7];
            lin_reload_d = wr_data[LIN_W-1:0];
        end
        if (wr_tlo) begin
            period_d[7:0] = wr_data;
        end
        if (wr_thi) begin
            period_d[TIMER_W-1:8] = wr_data[TIMER_W-9:0];
        end

        // Quarter-frame sees the registered ctrl/reload values, so a same-cycle write lands afterwards.
        if (quarter_frame) begin
            if (reload_flag_q) begin
                linear_d = lin_reload_q;
            end else if (linear_q != '0) begin
                linear_d = linear_q - LIN_W'(1);
            end
            if (!ctrl_q) begin
                reload_flag_d = 1'b0;
            end
        end
        if (wr_thi) begin
            reload_flag_d = 1'b1;
        end

        if (step_tick && (linear_q != '0) && (length_count != '0) && period_ok) begin
            step_d = step_q + (OUT_W + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q        <= 1'b0;
            lin_reload_q  <= '0;
            period_q      <= '0;
            timer_q       <= '0;
            linear_q      <= '0;
            reload_flag_q <= 1'b0;
            step_q        <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            lin_reload_q  <= lin_reload_d;
            period_q      <= period_d;
            timer_q       <= timer_d;
            linear_q      <= linear_d;
            reload_flag_q <= reload_flag_d;
            step_q        <= step_d;
        end
    end

    apu_length_counter #(
        .LEN_W(LEN_W)
    ) u_length (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (wr_thi),
        .load_val  (LEN_W'(length_lookup(wr_data[7:3]))),
        .halt      (ctrl_q),
        .half_frame(half_frame),
        .enable    (enable),
        .count     (length_count),
        .active    (length_active)
    );

    // First half of the sequence counts down, second half counts up.
    assign wave = step_q[OUT_W] ? step_q[OUT_W-1:0] : ~step_q[OUT_W-1:0];

endmodule

// File: tb/tb_triangle_channel_gen.sv
// Directed bench for triangle_channel_gen with hand-computed expected samples.
module tb_triangle_channel_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       quarter_frame = 1'b0;
    logic       half_frame = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] wave;
    logic       length_active;

    int checks = 0;
    int errors = 0;

    triangle_channel_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .quarter_frame(quarter_frame),
        .half_frame   (half_frame),
        .enable       (enable),
        .wave         (wave),
        .length_active(length_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
        $display("check %-14s observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic qf();
        quarter_frame = 1'b1;
        tick();
        quarter_frame = 1'b0;
    endtask

    task automatic hf();
        half_frame = 1'b1;
        tick();
        half_frame = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Advance until wave leaves 'from'; a blown budget shows up as a failed check.
    task automatic wait_change(input string tag, input logic [3:0] from, input int budget);
        int n;
        n = 0;
        while (wave === from && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Sequence after steps 1..32 at the default width: 14..0, 0..15, then 15.
    logic [3:0] wrap_exp [0:31] = '{
        4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7,
        4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1, 4'd0, 4'd0,
        4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6, 4'd7, 4'd8,
        4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15
    };

    initial begin
        logic [3:0] held;
        logic       moved;

        // Reset state
        #3;
        chk("rst_wave", wave, 4'd15);
        chk("rst_active", length_active, 1'b0);
        rst_n = 1'b1;
        tick();

        // Test 1: ctrl=1, period 3, length 254, linear 1 -> steps every 4 clk
        enable = 1'b1;
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h08);
        chk("t1_active", length_active, 1'b1);
        chk("t1_prefreeze", wave, 4'd15);
        qf();
        wait_change("t1_start", 4'd15, 20);
        chk("t1_first", wave, 4'd14);
        for (int s = 0; s < 3; s++) begin
            repeat (3) tick();
            chk("t1_hold", wave, 32'(14 - s));
            tick();
            chk("t1_step", wave, 32'(13 - s));
        end

        // Asynchronous reset mid-sequence (wave currently 11)
        rst_n = 1'b0;
        #1;
        chk("arst_wave", wave, 4'd15);
        chk("arst_active", length_active, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();

        // Test 2: ctrl=0, linear runs down 1 -> 0 and the sequencer freezes
        wr(2'd0, 8'h01);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h08);
        qf();
        wait_change("t2_run", 4'd15, 20);
        chk("t2_first", wave, 4'd14);
        qf();
        held = wave;
        moved = 1'b0;
        repeat (100) begin
            tick();
            if (wave !== held) moved = 1'b1;
        end
        chk("t2_frozen", moved, 1'b0);

        // Test 3: length decay from 2 over two half frames
        do_reset();
        wr(2'd0, 8'h7F);
        wr(2'd2, 8'h03);
        wr(2'd3, 8'h18);
        qf();
        hf();
        chk("t3_len1", length_active, 1'b1);
        hf();
        chk("t3_len0", length_active, 1'b0);
        held = wave;
        moved = 1'b0;
        repeat (50) begin
            tick();
            if (wave !== held) moved = 1'b1;
        end
        chk("t3_frozen", moved, 1'b0);

        // Test 4: enable low clears length and blocks loads
        do_reset();
        wr(2'd0, 8'h81);
        wr(2'd3, 8'h08);
        chk("t4_loaded", length_active, 1'b1);
        enable = 1'b0;
        tick();
        chk("t4_disabled", length_active, 1'b0);
        wr(2'd3, 8'h08);
        chk("t4_blocked", length_active, 1'b0);
        enable = 1'b1;
        tick();
        chk("t4_reenable", length_active, 1'b0);

        // Test 5: period 1 is suppressed; period 2 steps every 3 clk through a full wrap
        do_reset();
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h08);
        qf();
        moved = 1'b0;
        repeat (40) begin
            tick();
            if (wave !== 4'd15) moved = 1'b1;
        end
        chk("t5_suppress", moved, 1'b0);
        wr(2'd2, 8'h02);
        wait_change("t5_resume", 4'd15, 10);
        chk("t5_step1", wave, wrap_exp[0]);
        for (int s = 1; s < 32; s++) begin
            repeat (2) tick();
            if (s < 4) chk("t5_hold", wave, wrap_exp[s-1]);
            tick();
            chk("t5_wrap", wave, wrap_exp[s]);
        end

        // Test 6: addr-3 write coinciding with half_frame -> load wins
        do_reset();
        wr(2'd0, 8'h01);
        wr(2'd3, 8'h18);
        hf();
        half_frame = 1'b1;
        wr(2'd3, 8'h18);
        half_frame = 1'b0;
        hf();
        chk("t6_after1", length_active, 1'b1);
        hf();
        chk("t6_after2", length_active, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
